// File: rtl/pfu_pkg.sv
// Program fetch unit shared definitions.
// Default geometry and the per-edge action the fetch control selects.
package pfu_pkg;

    localparam int unsigned PFU_ADDR_W    = 16;
    localparam int unsigned PFU_INS_W     = 32;
    localparam int unsigned PFU_DEPTH     = 256;
    localparam int unsigned PFU_RESET_VEC = 0;
    localparam logic [31:0] PFU_NOP_WORD  = 32'h0;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_JUMP,
        ACT_FETCH
    } pfu_act_e;

endpackage

// File: rtl/pfu_rom.sv
// Program store: one synchronous read port, one write port, read-before-write.
// Ports: clk_i, re_i/raddr_i -> rdata_o (held when re_i=0), we_i/waddr_i/wdata_i.
module pfu_rom
    import pfu_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Both non-blocking: a same-edge read sees the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_fetch_unit.sv
// Program fetch unit: PC, jump/stall control, pending jump, registered outputs.
// Ports: clk, reset (async low), jump_en/jump_loc, stall, stall_pm,
// prog_we/prog_addr/prog_data (loader), ins, current_address, ins_valid, addr_err.
module program_fetch_unit
    import pfu_pkg::*;
#(
    parameter int ADDR_W                = PFU_ADDR_W,
    parameter int INS_W                 = PFU_INS_W,
    parameter int DEPTH                 = PFU_DEPTH,
    parameter int RESET_VEC             = PFU_RESET_VEC,
    parameter logic [INS_W-1:0] NOP_WORD = INS_W'(PFU_NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_loc,
    input  logic              stall,
    input  logic              stall_pm,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INS_W-1:0]  prog_data,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] current_address,
    output logic              ins_valid,
    output logic              addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ca_q, ca_d;
    logic [ADDR_W-1:0] ploc_q, ploc_d;
    logic              pend_q, pend_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    // Set when ins should show the ROM read register rather than NOP_WORD.
    logic              sel_q, sel_d;

    logic              rd_en;
    logic              pc_in_rng;
    logic              wr_in_rng;
    logic [INS_W-1:0]  rom_rdata;
    pfu_act_e          act;

    assign pc_in_rng = (pc_q >> AW) == '0;
    assign wr_in_rng = (prog_addr >> AW) == '0;

    pfu_rom #(
        .AW (AW),
        .DW (INS_W)
    ) u_rom (
        .clk_i   (clk),
        .re_i    (rd_en),
        .raddr_i (pc_q[AW-1:0]),
        .rdata_o (rom_rdata),
        .we_i    (prog_we && wr_in_rng),
        .waddr_i (prog_addr[AW-1:0]),
        .wdata_i (prog_data)
    );

    // stall beats stall_pm; any jump (live or pending) beats a fetch.
    always_comb begin
        act = ACT_FETCH;
        if (stall) begin
            act = ACT_HOLD;
        end else if (stall_pm) begin
            act = ACT_BUBBLE;
        end else if (jump_en || pend_q) begin
            act = ACT_JUMP;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        ca_d   = ca_q;
        ploc_d = ploc_q;
        pend_d = pend_q;
        vld_d  = vld_q;
        err_d  = err_q;
        sel_d  = sel_q;
        rd_en  = 1'b0;
        unique case (act)
            ACT_HOLD: begin
                if (jump_en) begin
                    pend_d = 1'b1;
                    ploc_d = jump_loc;
                end
            end
            ACT_BUBBLE: begin
                if (jump_en) begin
                    pend_d = 1'b1;
                    ploc_d = jump_loc;
                end
                vld_d = 1'b0;
                err_d = 1'b0;
                sel_d = 1'b0;
            end
            ACT_JUMP: begin
                pc_d   = jump_en ? jump_loc : ploc_q;
                pend_d = 1'b0;
                vld_d  = 1'b0;
                err_d  = 1'b0;
                sel_d  = 1'b0;
            end
            ACT_FETCH: begin
                pc_d  = pc_q + 1'b1;
                ca_d  = pc_q;
                vld_d = 1'b1;
                err_d = !pc_in_rng;
                sel_d = pc_in_rng;
                rd_en = pc_in_rng;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RST_PC;
            ca_q   <= RST_PC;
            ploc_q <= '0;
            pend_q <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ca_q   <= ca_d;
            ploc_q <= ploc_d;
            pend_q <= pend_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            sel_q  <= sel_d;
        end
    end

    // ROM data is only selected after an in-range fetch; it holds otherwise.
    assign ins             = sel_q ? rom_rdata : NOP_WORD;
    assign current_address = ca_q;
    assign ins_valid       = vld_q;
    assign addr_err        = err_q;

endmodule
